// File: rtl/seq_gen_1010.sv
// seq_gen_1010: serial pattern transmitter feeding Mealy 1010 detectors.
// Define SEQ_GAP_EN to insert GAP idle cycles between consecutive frames.
module seq_gen_1010 #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               CNT_W   = 4,
    parameter int               GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             ready,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(PAT_W);
    localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);

    if (PAT_W < 2 || GAP < 1) begin : g_bad_param
        $error("seq_gen_1010: PAT_W must be >= 2 and GAP >= 1");
    end

`ifdef SEQ_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_SEND, S_GAP, S_DONE
    } state_t;

    logic [GW-1:0] gcnt, gcnt_n;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_SEND, S_DONE
    } state_t;
`endif

    state_t           state, state_n;
    logic [PAT_W-1:0] sreg, sreg_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CNT_W-1:0] frames, frames_n;

    logic out_d, valid_d, busy_d, done_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            sreg   <= '0;
            idx    <= '0;
            frames <= '0;
`ifdef SEQ_GAP_EN
            gcnt   <= '0;
`endif
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            idx    <= idx_n;
            frames <= frames_n;
`ifdef SEQ_GAP_EN
            gcnt   <= gcnt_n;
`endif
        end
    end

    // Next state: frame sequencing, shifting and frame counting.
    always_comb begin
        state_n  = state;
        sreg_n   = sreg;
        idx_n    = idx;
        frames_n = frames;
`ifdef SEQ_GAP_EN
        gcnt_n   = gcnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        sreg_n   = PATTERN;
                        frames_n = count;
                        idx_n    = '0;
                        state_n  = S_SEND;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (ready) begin
                    if (idx == LAST) begin
                        idx_n    = '0;
                        frames_n = frames - 1'b1;
                        if (frames != CNT_W'(1)) begin
                            sreg_n = PATTERN;
`ifdef SEQ_GAP_EN
                            gcnt_n  = '0;
                            state_n = S_GAP;
`else
                            state_n = S_SEND;
`endif
                        end else begin
                            state_n = S_DONE;
                        end
                    end else begin
                        sreg_n = sreg << 1;
                        idx_n  = idx + 1'b1;
                    end
                end
            end
`ifdef SEQ_GAP_EN
            S_GAP: begin
                if (gcnt == GLAST) begin
                    state_n = S_SEND;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs can be registered.
    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        unique case (1'b1)
            (state_n == S_IDLE): busy_d = 1'b0;
            (state_n == S_SEND): begin
                valid_d = 1'b1;
                out_d   = sreg_n[PAT_W-1];
            end
            (state_n == S_DONE): done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            out   <= out_d;
            valid <= valid_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule
